// File: rtl/data_memory_stage.sv
// ---------------------------------------------------------------------------
// data_memory_stage
//
// Pipeline memory-access stage. Takes the load/store control, effective
// address, store data and write-back fields from the execution stage, runs
// loads and stores over a single-port request/response memory interface,
// and registers the results toward write-back. A three-state FSM
// (IDLE/REQ/WAIT) holds the upstream pipeline until the memory completes.
//
// Ports:
//   CLK, RST                   clock (rising edge), synchronous active-high reset
//   RD_ADDRESS_IN              destination register from execution stage
//   ALU_OUT_IN                 ALU result / effective address
//   DATA_CACHE_LOAD_IN         000 none, 001 LB, 010 LH, 011 LW, 100 LBU, 101 LHU
//   DATA_CACHE_STORE_IN        00 none, 01 SB, 10 SH, 11 SW
//   DATA_CACHE_STORE_DATA_IN   store source (rs2)
//   WRITE_BACK_MUX_SELECT_IN   write-back select, passed through
//   RD_WRITE_ENABLE_IN         register-file write enable, passed through
//   MEM_REQ_VALID/READY        request handshake
//   MEM_ADDR/WE/WSTRB/WDATA    request payload (word address, lane strobes)
//   MEM_RESP_VALID, MEM_RDATA  read response
//   STALL_MEMORY_STAGE         combinational hold for execution stage and earlier
//   RD_ADDRESS_OUT, ALU_OUT, LOAD_DATA_OUT,
//   WRITE_BACK_MUX_SELECT_OUT, RD_WRITE_ENABLE_OUT   registered to write-back
//   MISALIGNED_OUT             registered one-cycle misalignment flag
//
// Configuration macro: DATA_MEMORY_MISALIGN_TRAP_EN
//   defined   - misaligned LH/LHU/SH/LW/SW issue no request, register a
//               bubble and raise MISALIGNED_OUT for one cycle.
//   undefined - no detection; halfwords use addr[1] only, words ignore
//               addr[1:0]; MISALIGNED_OUT stays 0.
// ---------------------------------------------------------------------------
module data_memory_stage #(
    parameter logic HIGH = 1'b1,
    parameter logic LOW  = 1'b0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [4:0]  RD_ADDRESS_IN,
    input  logic [31:0] ALU_OUT_IN,
    input  logic [2:0]  DATA_CACHE_LOAD_IN,
    input  logic [1:0]  DATA_CACHE_STORE_IN,
    input  logic [31:0] DATA_CACHE_STORE_DATA_IN,
    input  logic        WRITE_BACK_MUX_SELECT_IN,
    input  logic        RD_WRITE_ENABLE_IN,
    output logic        MEM_REQ_VALID,
    input  logic        MEM_REQ_READY,
    output logic [31:0] MEM_ADDR,
    output logic        MEM_WE,
    output logic [3:0]  MEM_WSTRB,
    output logic [31:0] MEM_WDATA,
    input  logic        MEM_RESP_VALID,
    input  logic [31:0] MEM_RDATA,
    output logic        STALL_MEMORY_STAGE,
    output logic [4:0]  RD_ADDRESS_OUT,
    output logic [31:0] ALU_OUT,
    output logic [31:0] LOAD_DATA_OUT,
    output logic        WRITE_BACK_MUX_SELECT_OUT,
    output logic        RD_WRITE_ENABLE_OUT,
    output logic        MISALIGNED_OUT
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

    localparam logic [2:0] LD_LB  = 3'b001;
    localparam logic [2:0] LD_LH  = 3'b010;
    localparam logic [2:0] LD_LW  = 3'b011;
    localparam logic [2:0] LD_LBU = 3'b100;
    localparam logic [2:0] LD_LHU = 3'b101;
    localparam logic [1:0] ST_SB  = 2'b01;
    localparam logic [1:0] ST_SH  = 2'b10;
    localparam logic [1:0] ST_SW  = 2'b11;

    state_e state_q, state_d;

    logic [4:0]  rd_address_q, rd_address_d;
    logic [31:0] alu_q, alu_d;
    logic [31:0] load_data_q, load_data_d;
    logic        wb_sel_q, wb_sel_d;
    logic        rd_we_q, rd_we_d;
    logic        misaligned_q, misaligned_d;

    logic        is_load, is_store, mem_op, trap;
    logic [1:0]  off;
    logic        stall, req_valid, store_done, load_done;
    logic [3:0]  st_strb;
    logic [31:0] st_data;
    logic [1:0]  ld_off;
    logic [31:0] ld_shifted;
    logic [31:0] ld_data;

    // ---------------------------------------------------------------- decode
    // Codes 110/111 are not loads; a valid load wins over any store code.
    assign is_load  = (DATA_CACHE_LOAD_IN != 3'b000) && (DATA_CACHE_LOAD_IN <= LD_LHU);
    assign is_store = !is_load && (DATA_CACHE_STORE_IN != 2'b00);
    assign mem_op   = is_load || is_store;
    assign off      = ALU_OUT_IN[1:0];

`ifdef DATA_MEMORY_MISALIGN_TRAP_EN
    logic is_half, is_word;
    assign is_half = (is_load && (DATA_CACHE_LOAD_IN == LD_LH || DATA_CACHE_LOAD_IN == LD_LHU))
                  || (is_store && DATA_CACHE_STORE_IN == ST_SH);
    assign is_word = (is_load && DATA_CACHE_LOAD_IN == LD_LW)
                  || (is_store && DATA_CACHE_STORE_IN == ST_SW);
    assign trap    = (is_half && off[0]) || (is_word && (off != 2'b00));
`else
    assign trap    = LOW;
`endif

    // ------------------------------------------------------- store lanes
    always_comb begin
        // NOTE: every combinational output gets a default first so that no
        // path through the case leaves it unassigned (which would infer a latch).
        st_strb = 4'b0000;
        st_data = 32'h0;
        unique case (DATA_CACHE_STORE_IN)
            ST_SB: begin
                st_strb = 4'b0001 << off;
                st_data = {4{DATA_CACHE_STORE_DATA_IN[7:0]}};
            end
            ST_SH: begin
                st_strb = 4'b0011 << {off[1], 1'b0};
                st_data = {2{DATA_CACHE_STORE_DATA_IN[15:0]}};
            end
            ST_SW: begin
                st_strb = 4'b1111;
                st_data = DATA_CACHE_STORE_DATA_IN;
            end
            default: ;
        endcase
    end

    // -------------------------------------------------------- load extract
    // Halfwords only look at addr[1]; words ignore the low address bits.
    always_comb begin
        ld_off = 2'b00;
        unique case (DATA_CACHE_LOAD_IN)
            LD_LB, LD_LBU: ld_off = off;
            LD_LH, LD_LHU: ld_off = {off[1], 1'b0};
            default:       ld_off = 2'b00;
        endcase
    end

    assign ld_shifted = MEM_RDATA >> {ld_off, 3'b000};

    always_comb begin
        ld_data = 32'h0;
        unique case (DATA_CACHE_LOAD_IN)
            LD_LB:   ld_data = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
            LD_LH:   ld_data = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
            LD_LW:   ld_data = MEM_RDATA;
            LD_LBU:  ld_data = {24'h0, ld_shifted[7:0]};
            LD_LHU:  ld_data = {16'h0, ld_shifted[15:0]};
            default: ld_data = 32'h0;
        endcase
    end

    // ------------------------------------------------------------------ FSM
    always_comb begin
        state_d    = state_q;
        stall      = LOW;
        req_valid  = LOW;
        store_done = LOW;
        load_done  = LOW;
        unique case (state_q)
            S_IDLE: begin
                if (mem_op && !trap) begin
                    stall   = HIGH;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                req_valid = HIGH;
                if (MEM_REQ_READY && is_store) begin
                    store_done = HIGH;
                    state_d    = S_IDLE;
                end else begin
                    stall = HIGH;
                    if (MEM_REQ_READY) state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (MEM_RESP_VALID) begin
                    load_done = HIGH;
                    state_d   = S_IDLE;
                end else begin
                    stall = HIGH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output registers: a bubble while stalled, otherwise pass-through.
    always_comb begin
        rd_address_d = '0;
        alu_d        = '0;
        load_data_d  = '0;
        wb_sel_d     = LOW;
        rd_we_d      = LOW;
        misaligned_d = LOW;
        if (state_q == S_IDLE && mem_op && trap) begin
            misaligned_d = HIGH;
        end else if (!stall) begin
            rd_address_d = RD_ADDRESS_IN;
            alu_d        = ALU_OUT_IN;
            wb_sel_d     = WRITE_BACK_MUX_SELECT_IN;
            rd_we_d      = RD_WRITE_ENABLE_IN;
            load_data_d  = load_done ? ld_data : 32'h0;
        end
    end

    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments, and reset is
        // sampled synchronously here rather than in the sensitivity list.
        if (RST) begin
            state_q      <= S_IDLE;
            rd_address_q <= '0;
            alu_q        <= '0;
            load_data_q  <= '0;
            wb_sel_q     <= LOW;
            rd_we_q      <= LOW;
            misaligned_q <= LOW;
        end else begin
            state_q      <= state_d;
            rd_address_q <= rd_address_d;
            alu_q        <= alu_d;
            load_data_q  <= load_data_d;
            wb_sel_q     <= wb_sel_d;
            rd_we_q      <= rd_we_d;
            misaligned_q <= misaligned_d;
        end
    end

    // ------------------------------------------------------------ outputs
    // Request and stall are masked by RST so the interface reads idle while
    // reset is held, even if the upstream is still presenting an op.
    assign MEM_REQ_VALID      = req_valid && !RST;
    assign STALL_MEMORY_STAGE = stall && !RST;
    assign MEM_ADDR           = MEM_REQ_VALID ? {ALU_OUT_IN[31:2], 2'b00} : 32'h0;
    assign MEM_WE             = MEM_REQ_VALID && is_store;
    assign MEM_WSTRB          = MEM_WE ? st_strb : 4'b0000;
    assign MEM_WDATA          = MEM_WE ? st_data : 32'h0;

    assign RD_ADDRESS_OUT            = rd_address_q;
    assign ALU_OUT                   = alu_q;
    assign LOAD_DATA_OUT             = load_data_q;
    assign WRITE_BACK_MUX_SELECT_OUT = wb_sel_q;
    assign RD_WRITE_ENABLE_OUT       = rd_we_q;
    assign MISALIGNED_OUT            = misaligned_q;

endmodule

// File: tb/tb_data_memory_stage.sv
// ---------------------------------------------------------------------------
// tb_data_memory_stage
//
// Directed self-checking bench for data_memory_stage. Inputs are driven 1 ns
// after each rising edge; combinational outputs and registered outputs are
// sampled in the same low-risk window, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_data_memory_stage;

    logic        CLK = 1'b0;
    logic        RST;
    logic [4:0]  RD_ADDRESS_IN;
    logic [31:0] ALU_OUT_IN;
    logic [2:0]  DATA_CACHE_LOAD_IN;
    logic [1:0]  DATA_CACHE_STORE_IN;
    logic [31:0] DATA_CACHE_STORE_DATA_IN;
    logic        WRITE_BACK_MUX_SELECT_IN;
    logic        RD_WRITE_ENABLE_IN;
    logic        MEM_REQ_VALID;
    logic        MEM_REQ_READY;
    logic [31:0] MEM_ADDR;
    logic        MEM_WE;
    logic [3:0]  MEM_WSTRB;
    logic [31:0] MEM_WDATA;
    logic        MEM_RESP_VALID;
    logic [31:0] MEM_RDATA;
    logic        STALL_MEMORY_STAGE;
    logic [4:0]  RD_ADDRESS_OUT;
    logic [31:0] ALU_OUT;
    logic [31:0] LOAD_DATA_OUT;
    logic        WRITE_BACK_MUX_SELECT_OUT;
    logic        RD_WRITE_ENABLE_OUT;
    logic        MISALIGNED_OUT;

    int total_checks  = 0;
    int passed_checks = 0;

    always #5 CLK = ~CLK;

    data_memory_stage dut (
        .CLK                       (CLK),
        .RST                       (RST),
        .RD_ADDRESS_IN             (RD_ADDRESS_IN),
        .ALU_OUT_IN                (ALU_OUT_IN),
        .DATA_CACHE_LOAD_IN        (DATA_CACHE_LOAD_IN),
        .DATA_CACHE_STORE_IN       (DATA_CACHE_STORE_IN),
        .DATA_CACHE_STORE_DATA_IN  (DATA_CACHE_STORE_DATA_IN),
        .WRITE_BACK_MUX_SELECT_IN  (WRITE_BACK_MUX_SELECT_IN),
        .RD_WRITE_ENABLE_IN        (RD_WRITE_ENABLE_IN),
        .MEM_REQ_VALID             (MEM_REQ_VALID),
        .MEM_REQ_READY             (MEM_REQ_READY),
        .MEM_ADDR                  (MEM_ADDR),
        .MEM_WE                    (MEM_WE),
        .MEM_WSTRB                 (MEM_WSTRB),
        .MEM_WDATA                 (MEM_WDATA),
        .MEM_RESP_VALID            (MEM_RESP_VALID),
        .MEM_RDATA                 (MEM_RDATA),
        .STALL_MEMORY_STAGE        (STALL_MEMORY_STAGE),
        .RD_ADDRESS_OUT            (RD_ADDRESS_OUT),
        .ALU_OUT                   (ALU_OUT),
        .LOAD_DATA_OUT             (LOAD_DATA_OUT),
        .WRITE_BACK_MUX_SELECT_OUT (WRITE_BACK_MUX_SELECT_OUT),
        .RD_WRITE_ENABLE_OUT       (RD_WRITE_ENABLE_OUT),
        .MISALIGNED_OUT            (MISALIGNED_OUT)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total_checks++;
        assert (observed === expected) passed_checks++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        RD_ADDRESS_IN            = '0;
        ALU_OUT_IN               = '0;
        DATA_CACHE_LOAD_IN       = '0;
        DATA_CACHE_STORE_IN      = '0;
        DATA_CACHE_STORE_DATA_IN = '0;
        WRITE_BACK_MUX_SELECT_IN = 1'b0;
        RD_WRITE_ENABLE_IN       = 1'b0;
    endtask

    // Full load: IDLE (stall), REQ accepted at once, WAIT for resp_delay
    // extra cycles, then the response; result appears after the next edge.
    task automatic run_load(input string tag, input logic [2:0] op, input logic [31:0] addr,
                            input logic [31:0] rdata, input int resp_delay,
                            input logic [31:0] expected);
        DATA_CACHE_LOAD_IN = op;
        ALU_OUT_IN         = addr;
        RD_ADDRESS_IN      = 5'd3;
        RD_WRITE_ENABLE_IN = 1'b1;
        MEM_REQ_READY      = 1'b1;
        MEM_RESP_VALID     = 1'b0;
        MEM_RDATA          = rdata;
        #1;
        check({tag, "_idle_stall"}, STALL_MEMORY_STAGE, 1);
        check({tag, "_idle_novalid"}, MEM_REQ_VALID, 0);
        tick();
        check({tag, "_req_valid"}, MEM_REQ_VALID, 1);
        check({tag, "_req_addr"}, MEM_ADDR, {addr[31:2], 2'b00});
        check({tag, "_req_we"}, MEM_WE, 0);
        check({tag, "_req_wstrb"}, MEM_WSTRB, 0);
        check({tag, "_req_stall"}, STALL_MEMORY_STAGE, 1);
        check({tag, "_req_bubble"}, RD_WRITE_ENABLE_OUT, 0);
        tick();
        for (int i = 0; i < resp_delay; i++) begin
            check({tag, "_wait_stall"}, STALL_MEMORY_STAGE, 1);
            check({tag, "_wait_novalid"}, MEM_REQ_VALID, 0);
            check({tag, "_wait_bubble"}, RD_WRITE_ENABLE_OUT, 0);
            tick();
        end
        MEM_RESP_VALID = 1'b1;
        #1;
        check({tag, "_resp_nostall"}, STALL_MEMORY_STAGE, 0);
        tick();
        check({tag, "_load_data"}, LOAD_DATA_OUT, expected);
        check({tag, "_rd_we"}, RD_WRITE_ENABLE_OUT, 1);
        check({tag, "_rd_addr"}, RD_ADDRESS_OUT, 3);
        check({tag, "_alu"}, ALU_OUT, addr);
        MEM_RESP_VALID = 1'b0;
        clear_inputs();
        #1;
    endtask

    initial begin
        RST            = 1'b1;
        MEM_REQ_READY  = 1'b0;
        MEM_RESP_VALID = 1'b0;
        MEM_RDATA      = '0;
        clear_inputs();
        tick();
        tick();

        // Reset state.
        check("rst_valid", MEM_REQ_VALID, 0);
        check("rst_stall", STALL_MEMORY_STAGE, 0);
        check("rst_rd_we", RD_WRITE_ENABLE_OUT, 0);
        check("rst_alu", ALU_OUT, 0);
        check("rst_load", LOAD_DATA_OUT, 0);
        check("rst_misaligned", MISALIGNED_OUT, 0);
        RST = 1'b0;

        // Non-memory op: one-cycle pass-through, never stalls.
        ALU_OUT_IN               = 32'h0000_1234;
        RD_ADDRESS_IN            = 5'd5;
        RD_WRITE_ENABLE_IN       = 1'b1;
        WRITE_BACK_MUX_SELECT_IN = 1'b1;
        #1;
        check("add_nostall", STALL_MEMORY_STAGE, 0);
        check("add_novalid", MEM_REQ_VALID, 0);
        tick();
        check("add_alu", ALU_OUT, 32'h0000_1234);
        check("add_rd", RD_ADDRESS_OUT, 5);
        check("add_we", RD_WRITE_ENABLE_OUT, 1);
        check("add_wbsel", WRITE_BACK_MUX_SELECT_OUT, 1);
        check("add_load", LOAD_DATA_OUT, 0);
        clear_inputs();

        // SB at 0x103 with READY low for two REQ cycles: stall is high in
        // IDLE and both waiting REQ cycles, low in the accepting cycle.
        DATA_CACHE_STORE_IN      = 2'b01;
        ALU_OUT_IN               = 32'h0000_0103;
        DATA_CACHE_STORE_DATA_IN = 32'h1234_56A5;
        RD_ADDRESS_IN            = 5'd7;
        MEM_REQ_READY            = 1'b0;
        #1;
        check("sb_idle_stall", STALL_MEMORY_STAGE, 1);
        tick();
        check("sb_req_valid", MEM_REQ_VALID, 1);
        check("sb_req_addr", MEM_ADDR, 32'h0000_0100);
        check("sb_req_we", MEM_WE, 1);
        check("sb_req_wstrb", MEM_WSTRB, 4'b1000);
        check("sb_req_wdata", MEM_WDATA, 32'hA5A5_A5A5);
        check("sb_req1_stall", STALL_MEMORY_STAGE, 1);
        check("sb_bubble_rd", RD_ADDRESS_OUT, 0);
        tick();
        check("sb_req2_stall", STALL_MEMORY_STAGE, 1);
        check("sb_req2_wstrb", MEM_WSTRB, 4'b1000);
        MEM_REQ_READY = 1'b1;
        #1;
        check("sb_accept_nostall", STALL_MEMORY_STAGE, 0);
        tick();
        check("sb_done_alu", ALU_OUT, 32'h0000_0103);
        check("sb_done_rd", RD_ADDRESS_OUT, 7);
        check("sb_done_we", RD_WRITE_ENABLE_OUT, 0);
        clear_inputs();
        #1;
        check("sb_after_novalid", MEM_REQ_VALID, 0);

        // SH at 0x102 (upper half) and SW, READY immediately.
        DATA_CACHE_STORE_IN      = 2'b10;
        ALU_OUT_IN               = 32'h0000_0102;
        DATA_CACHE_STORE_DATA_IN = 32'h0000_BEEF;
        tick();
        check("sh_wstrb", MEM_WSTRB, 4'b1100);
        check("sh_wdata", MEM_WDATA, 32'hBEEF_BEEF);
        check("sh_accept_nostall", STALL_MEMORY_STAGE, 0);
        tick();
        DATA_CACHE_STORE_IN      = 2'b11;
        ALU_OUT_IN               = 32'h0000_0200;
        DATA_CACHE_STORE_DATA_IN = 32'hCAFE_F00D;
        tick();
        check("sw_wstrb", MEM_WSTRB, 4'b1111);
        check("sw_wdata", MEM_WDATA, 32'hCAFE_F00D);
        check("sw_addr", MEM_ADDR, 32'h0000_0200);
        tick();
        clear_inputs();

        // Loads with sign/zero extension.
        run_load("lb", 3'b001, 32'h0000_0102, 32'h0080_0000, 0, 32'hFFFF_FF80);
        DATA_CACHE_STORE_IN = 2'b11;  // load has priority; store field ignored
        run_load("lbu", 3'b100, 32'h0000_0102, 32'h0080_0000, 0, 32'h0000_0080);
        run_load("lb3", 3'b001, 32'h0000_0103, 32'h7F00_0000, 0, 32'h0000_007F);
        run_load("lh", 3'b010, 32'h0000_0102, 32'h8001_0000, 0, 32'hFFFF_8001);
        run_load("lhu", 3'b101, 32'h0000_0102, 32'h8001_0000, 0, 32'h0000_8001);
        run_load("lw", 3'b011, 32'h0000_0104, 32'hDEAD_BEEF, 3, 32'hDEAD_BEEF);

        // Reset while waiting for the response: nothing is written back,
        // and a late response is ignored.
        DATA_CACHE_LOAD_IN = 3'b011;
        ALU_OUT_IN         = 32'h0000_0200;
        RD_ADDRESS_IN      = 5'd9;
        RD_WRITE_ENABLE_IN = 1'b1;
        MEM_REQ_READY      = 1'b1;
        tick();
        tick();
        check("rstw_waiting_stall", STALL_MEMORY_STAGE, 1);
        RST = 1'b1;
        tick();
        check("rstw_valid", MEM_REQ_VALID, 0);
        check("rstw_rd_we", RD_WRITE_ENABLE_OUT, 0);
        check("rstw_alu", ALU_OUT, 0);
        RST = 1'b0;
        clear_inputs();
        MEM_RESP_VALID = 1'b1;
        MEM_RDATA      = 32'h5555_AAAA;
        #1;
        check("rstw_late_novalid", MEM_REQ_VALID, 0);
        check("rstw_late_nostall", STALL_MEMORY_STAGE, 0);
        tick();
        check("rstw_late_rd_we", RD_WRITE_ENABLE_OUT, 0);
        check("rstw_late_load", LOAD_DATA_OUT, 0);
        MEM_RESP_VALID = 1'b0;

        // Misaligned LW at 0x102.
`ifdef DATA_MEMORY_MISALIGN_TRAP_EN
        DATA_CACHE_LOAD_IN = 3'b011;
        ALU_OUT_IN         = 32'h0000_0102;
        RD_ADDRESS_IN      = 5'd4;
        RD_WRITE_ENABLE_IN = 1'b1;
        #1;
        check("mis_novalid", MEM_REQ_VALID, 0);
        check("mis_nostall", STALL_MEMORY_STAGE, 0);
        tick();
        check("mis_flag", MISALIGNED_OUT, 1);
        check("mis_rd_we", RD_WRITE_ENABLE_OUT, 0);
        check("mis_novalid_after", MEM_REQ_VALID, 0);
        clear_inputs();
        tick();
        check("mis_flag_clear", MISALIGNED_OUT, 0);
`else
        run_load("lw_unaligned", 3'b011, 32'h0000_0102, 32'h1122_3344, 0, 32'h1122_3344);
        check("mis_tied_low", MISALIGNED_OUT, 0);
`endif

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
